// File: rtl/pdp1_ctrl_pkg.sv
// pdp1_ctrl_pkg
//   Shared definitions for the Spacewar! control path.
//   - joystick_emu bit indices (per-player nibble, P2 at offset 4)
//   - io_data bit positions of the 18-bit IOT 011 control word
//   - fire shaper state encoding
//   - build_io_word(): packs a shaped snapshot into the control word
package pdp1_ctrl_pkg;

    // Bit indices inside one player's nibble of joystick_emu.
    localparam int JOY_FIRE   = 0;
    localparam int JOY_CCW    = 1;
    localparam int JOY_THRUST = 2;
    localparam int JOY_CW     = 3;
    localparam int JOY_P2_OFS = 4;

    // Control word layout.
    localparam int IO_W         = 18;
    localparam int IO_P1_CCW    = 17;
    localparam int IO_P1_CW     = 16;
    localparam int IO_P1_THRUST = 15;
    localparam int IO_P1_FIRE   = 14;
    localparam int IO_P2_CCW    = 3;
    localparam int IO_P2_CW     = 2;
    localparam int IO_P2_THRUST = 1;
    localparam int IO_P2_FIRE   = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIRE = 2'd1,
        GAP  = 2'd2
    } fire_st_t;

    // Unused bit positions of the control word stay 0.
    function automatic logic [IO_W-1:0] build_io_word(input logic [7:0] shaped);
        logic [IO_W-1:0] w_word;
        w_word               = '0;
        w_word[IO_P1_CCW]    = shaped[JOY_CCW];
        w_word[IO_P1_CW]     = shaped[JOY_CW];
        w_word[IO_P1_THRUST] = shaped[JOY_THRUST];
        w_word[IO_P1_FIRE]   = shaped[JOY_FIRE];
        w_word[IO_P2_CCW]    = shaped[JOY_P2_OFS + JOY_CCW];
        w_word[IO_P2_CW]     = shaped[JOY_P2_OFS + JOY_CW];
        w_word[IO_P2_THRUST] = shaped[JOY_P2_OFS + JOY_THRUST];
        w_word[IO_P2_FIRE]   = shaped[JOY_P2_OFS + JOY_FIRE];
        return w_word;
    endfunction

endpackage

// File: rtl/pdp1_spacewar_ctrl_fire_shaper.sv
// fire_shaper
//   Per-player fire-rate shaping (hold/gap autofire), advancing once per frame.
//   Ports:
//     clk, rst_n : clock, asynchronous active-low reset
//     tick       : one-cycle frame pulse; the FSM only moves on this cycle
//     fire_in    : fire bit of the snapshot being taken on this tick
//     fire_out   : shaped fire, high while in FIRE
//   Parameters:
//     FIRE_HOLD  : frames fire stays high once accepted (1..15), a minimum
//     FIRE_GAP   : frames fire is forced low between holds (0..15)
module fire_shaper
    import pdp1_ctrl_pkg::*;
#(
    parameter int FIRE_HOLD = 2,
    parameter int FIRE_GAP  = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic fire_in,
    output logic fire_out
);

    localparam logic [3:0] HOLD_LOAD = 4'(FIRE_HOLD - 1);
    localparam logic [3:0] GAP_LOAD  = (FIRE_GAP > 0) ? 4'(FIRE_GAP - 1) : 4'd0;
    localparam logic       HAS_GAP   = (FIRE_GAP > 0);

    fire_st_t   r_state;
    fire_st_t   w_state_nxt;
    logic [3:0] r_fcnt;
    logic [3:0] w_fcnt_nxt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_fcnt  <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_fcnt  <= w_fcnt_nxt;
        end
    end

    // Counters run down regardless of fire_in; fire_in is only consulted when
    // a hold or gap has fully elapsed, so a released button never cuts a hold short.
    always_comb begin
        w_state_nxt = r_state;
        w_fcnt_nxt  = r_fcnt;
        if (tick) begin
            case (r_state)
                IDLE: begin
                    if (fire_in) begin
                        w_state_nxt = FIRE;
                        w_fcnt_nxt  = HOLD_LOAD;
                    end
                end
                FIRE: begin
                    if (r_fcnt != 4'd0) begin
                        w_fcnt_nxt = r_fcnt - 4'd1;
                    end else if (fire_in && HAS_GAP) begin
                        w_state_nxt = GAP;
                        w_fcnt_nxt  = GAP_LOAD;
                    end else if (fire_in) begin
                        w_fcnt_nxt = HOLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                GAP: begin
                    if (r_fcnt != 4'd0) begin
                        w_fcnt_nxt = r_fcnt - 4'd1;
                    end else if (fire_in) begin
                        w_state_nxt = FIRE;
                        w_fcnt_nxt  = HOLD_LOAD;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_fcnt_nxt  = 4'd0;
                end
            endcase
        end
    end

    assign fire_out = (r_state == FIRE);

endmodule

// File: rtl/pdp1_spacewar_ctrl.sv
// pdp1_spacewar_ctrl
//   Frame-synchronous joystick snapshot with autofire shaping, served to the
//   PDP-1 as the IOT 011 control word.
//   Ports:
//     clk, rst_n    : clock, asynchronous active-low reset
//     joystick_emu  : 8-bit button vector {P2 CW,thrust,CCW,fire, P1 CW,thrust,CCW,fire}
//     frame_tick    : one-cycle pulse per video frame, takes the snapshot
//     swap_players  : quasi-static, exchanges the player nibbles at snapshot
//     iot_req       : one-cycle read request from the CPU
//     iot_ack       : one-cycle acknowledge, exactly one cycle after iot_req
//     io_data       : 18-bit control word, valid while iot_ack, 0 otherwise
//     snap_dbg      : current shaped snapshot in joystick_emu bit order
//
//   Handshake: iot_req is a single-cycle pulse with no back-pressure. Each
//   request sampled on a rising edge yields iot_ack high for exactly the next
//   cycle, with io_data carrying the shaped snapshot as it stood when the
//   request was sampled (a coincident frame_tick does not affect it).
//   Back-to-back requests give back-to-back acks.
module pdp1_spacewar_ctrl
    import pdp1_ctrl_pkg::*;
#(
    parameter int FIRE_HOLD = 2,
    parameter int FIRE_GAP  = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [7:0]      joystick_emu,
    input  logic            frame_tick,
    input  logic            swap_players,
    input  logic            iot_req,
    output logic            iot_ack,
    output logic [IO_W-1:0] io_data,
    output logic [7:0]      snap_dbg
);

    logic [7:0]      r_sticky;
    logic [7:0]      w_capture;
    logic [7:0]      w_snap_nxt;
    // Rotate/thrust bits of the snapshot; the fire bits live in the shapers.
    logic [2:0]      r_p1_move;
    logic [2:0]      r_p2_move;
    logic            w_p1_fire;
    logic            w_p2_fire;
    logic [7:0]      w_shaped;
    logic            r_ack;
    logic [IO_W-1:0] r_io_data;

    // Presses seen on the tick cycle itself land in this snapshot and are
    // not carried into the next frame.
    assign w_capture  = r_sticky | joystick_emu;
    assign w_snap_nxt = swap_players ? {w_capture[3:0], w_capture[7:4]} : w_capture;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sticky  <= 8'd0;
            r_p1_move <= 3'd0;
            r_p2_move <= 3'd0;
        end else if (frame_tick) begin
            r_sticky  <= 8'd0;
            r_p1_move <= w_snap_nxt[JOY_CW:JOY_CCW];
            r_p2_move <= w_snap_nxt[JOY_P2_OFS+JOY_CW:JOY_P2_OFS+JOY_CCW];
        end else begin
            r_sticky  <= w_capture;
        end
    end

    fire_shaper #(
        .FIRE_HOLD (FIRE_HOLD),
        .FIRE_GAP  (FIRE_GAP)
    ) u_fire_p1 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .fire_in  (w_snap_nxt[JOY_FIRE]),
        .fire_out (w_p1_fire)
    );

    fire_shaper #(
        .FIRE_HOLD (FIRE_HOLD),
        .FIRE_GAP  (FIRE_GAP)
    ) u_fire_p2 (
        .clk      (clk),
        .rst_n    (rst_n),
        .tick     (frame_tick),
        .fire_in  (w_snap_nxt[JOY_P2_OFS + JOY_FIRE]),
        .fire_out (w_p2_fire)
    );

    assign w_shaped = {r_p2_move, w_p2_fire, r_p1_move, w_p1_fire};

    // w_shaped still holds the pre-tick snapshot on the request cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_io_data <= '0;
        end else begin
            r_ack     <= iot_req;
            r_io_data <= iot_req ? build_io_word(w_shaped) : '0;
        end
    end

    assign iot_ack  = r_ack;
    assign io_data  = r_io_data;
    assign snap_dbg = w_shaped;

endmodule

// File: tb/tb_pdp1_spacewar_ctrl.sv
module tb_pdp1_spacewar_ctrl;

    localparam int H = 2;
    localparam int G = 3;
    localparam int P = H + G;

    logic        clk          = 1'b0;
    logic        rst_n        = 1'b0;
    logic [7:0]  joystick_emu = 8'd0;
    logic        frame_tick   = 1'b0;
    logic        swap_players = 1'b0;
    logic        iot_req      = 1'b0;
    logic        iot_ack;
    logic [17:0] io_data;
    logic [7:0]  snap_dbg;

    int n_checks = 0;
    int n_errors = 0;
    logic cmp_en = 1'b0;

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    pdp1_spacewar_ctrl #(
        .FIRE_HOLD (H),
        .FIRE_GAP  (G)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .joystick_emu (joystick_emu),
        .frame_tick   (frame_tick),
        .swap_players (swap_players),
        .iot_req      (iot_req),
        .iot_ack      (iot_ack),
        .io_data      (io_data),
        .snap_dbg     (snap_dbg)
    );

    // ---------------- behavioural model ----------------
    // Fire shaping viewed as "frames since the press was accepted" (age):
    // fire is on while age mod (H+G) < H; the button is only consulted when a
    // hold or a gap has just finished (age mod period == H or == 0).
    logic [7:0]  m_sticky = 8'd0;
    logic [7:0]  m_move   = 8'd0;
    logic [7:0]  m_shaped = 8'd0;
    logic        m_ack    = 1'b0;
    int          m_age [2] = '{-1, -1};
    logic [7:0]  m_cap;
    logic [7:0]  m_snap;
    logic [17:0] exp_q [$];

    function automatic int next_age(input int age, input logic fire);
        int a;
        if (age < 0) return fire ? 0 : -1;
        a = age + 1;
        if ((((a % P) == 0) || ((a % P) == H)) && !fire) return -1;
        return a;
    endfunction

    function automatic logic fire_on(input int age);
        return (age >= 0) && ((age % P) < H);
    endfunction

    function automatic logic [17:0] mword(input logic [7:0] s);
        logic [17:0] w;
        w = 18'd0;
        w[17] = s[1]; w[16] = s[3]; w[15] = s[2]; w[14] = s[0];
        w[3]  = s[5]; w[2]  = s[7]; w[1]  = s[6]; w[0]  = s[4];
        return w;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sticky = 8'd0;
            m_move   = 8'd0;
            m_shaped = 8'd0;
            m_ack    = 1'b0;
            m_age[0] = -1;
            m_age[1] = -1;
            exp_q.delete();
        end else begin
            m_ack = iot_req;
            if (iot_req) exp_q.push_back(mword(m_shaped));
            m_cap = m_sticky | joystick_emu;
            if (frame_tick) begin
                m_snap   = swap_players ? {m_cap[3:0], m_cap[7:4]} : m_cap;
                m_move   = m_snap;
                m_age[0] = next_age(m_age[0], m_snap[0]);
                m_age[1] = next_age(m_age[1], m_snap[4]);
                m_sticky = 8'd0;
            end else begin
                m_sticky = m_cap;
            end
            m_shaped    = m_move;
            m_shaped[0] = fire_on(m_age[0]);
            m_shaped[4] = fire_on(m_age[1]);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cyc_snap_dbg", 18'(snap_dbg), 18'(m_shaped));
            check("cyc_iot_ack", 18'(iot_ack), 18'(m_ack));
            if (m_ack) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL cyc_exp_q_underflow t=%0t", $time);
                end else begin
                    check("cyc_io_data", io_data, exp_q.pop_front());
                end
            end else begin
                check("cyc_io_data_idle", io_data, 18'd0);
            end
        end
    end

    // ---------------- driver ----------------
    task automatic cyc(input logic [7:0] joy, input logic tick, input logic req);
        joystick_emu = joy;
        frame_tick   = tick;
        iot_req      = req;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        iot_req    = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    logic [9:0] af_pat = 10'b0001100011;
    logic [7:0] hold_mask;
    logic [7:0] rnd;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("reset_snap", 18'(snap_dbg), 18'd0);
        check("reset_ack", 18'(iot_ack), 18'd0);
        check("reset_data", io_data, 18'd0);
        cmp_en = 1'b1;
        rst_n  = 1'b1;

        // short press
        cyc(8'h08, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        check("short_snap", 18'(snap_dbg), 18'h00008);
        cyc(8'h00, 1'b0, 1'b1);
        check("short_ack", 18'(iot_ack), 18'd1);
        check("short_data", io_data, 18'h10000);
        cyc(8'h00, 1'b0, 1'b0);
        check("short_ack_drop", 18'(iot_ack), 18'd0);
        cyc(8'h00, 1'b1, 1'b0);
        cyc(8'h00, 1'b0, 1'b1);
        check("short_next_frame", io_data, 18'd0);

        // autofire with P2 fire held
        for (int i = 0; i < 10; i++) begin
            cyc(8'h10, 1'b1, 1'b0);
            check("af_model", 18'(m_shaped[4]), 18'(af_pat[i]));
            check("af_snap", 18'(snap_dbg[4]), 18'(af_pat[i]));
            cyc(8'h10, 1'b0, 1'b1);
            check("af_data", 18'(io_data[0]), 18'(af_pat[i]));
        end
        repeat (3) cyc(8'h00, 1'b1, 1'b0);
        check("af_release", 18'(snap_dbg), 18'd0);

        // swap
        swap_players = 1'b1;
        cyc(8'h04, 1'b1, 1'b0);
        check("swap_snap", 18'(snap_dbg), 18'h00040);
        cyc(8'h00, 1'b0, 1'b1);
        check("swap_data", io_data, 18'h00002);
        swap_players = 1'b0;
        cyc(8'h00, 1'b1, 1'b0);

        // request coincident with a snapshot-changing tick
        cyc(8'h02, 1'b1, 1'b1);
        check("simul_ack", 18'(iot_ack), 18'd1);
        check("simul_old_data", io_data, 18'd0);
        cyc(8'h00, 1'b0, 1'b1);
        check("simul_new_data", io_data, 18'h20000);

        // back-to-back requests
        for (int i = 0; i < 3; i++) begin
            cyc(8'h00, 1'b0, 1'b1);
            check("b2b_ack", 18'(iot_ack), 18'd1);
            check("b2b_data", io_data, 18'h20000);
        end
        cyc(8'h00, 1'b0, 1'b0);
        check("b2b_ack_end", 18'(iot_ack), 18'd0);
        cyc(8'h00, 1'b1, 1'b0);

        // reset while in FIRE with an ack in flight
        cyc(8'h01, 1'b1, 1'b0);
        check("rst_fire_on", 18'(snap_dbg), 18'h00001);
        cyc(8'h01, 1'b0, 1'b1);
        check("rst_ack_pending", 18'(iot_ack), 18'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_snap", 18'(snap_dbg), 18'd0);
        check("rst_async_ack", 18'(iot_ack), 18'd0);
        check("rst_async_data", io_data, 18'd0);
        @(posedge clk);
        #1;
        check("rst_held_ack", 18'(iot_ack), 18'd0);
        rst_n = 1'b1;
        cyc(8'h01, 1'b0, 1'b0);
        check("rst_fire_needs_snap", 18'(snap_dbg), 18'd0);
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        // tick on the first edge after release
        cyc(8'h01, 1'b1, 1'b0);
        check("rst_first_tick", 18'(snap_dbg), 18'h00001);
        repeat (4) cyc(8'h00, 1'b1, 1'b0);

        // randomized traffic against the model
        hold_mask = 8'h00;
        for (int k = 0; k < 4000; k++) begin
            if ((k % 250) == 0) begin
                swap_players = 1'($urandom_range(0, 1));
                hold_mask    = 8'($urandom_range(0, 255)) & 8'h11;
            end
            rnd = 8'($urandom) & 8'($urandom) & 8'($urandom);
            cyc(rnd | hold_mask, ($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0));
            if (k == 2000) begin
                #2;
                rst_n = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
            end
        end

        repeat (3) cyc(8'h00, 1'b0, 1'b0);
        check("exp_q_drained", 18'(exp_q.size()), 18'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
